instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage for the segmented RISC-V core, sitting between the PC register and the IF/ID boundary. It consumes the PC value and drives the PC write enable back, so the PC advances only when a fetch is accepted. It issues requests to instruction memory over a valid/ready handshake, tags them with their PC, and buffers in-order responses in a small FIFO. It presents {instr, pc} to decode with a valid/ready handshake and supports a flush on branch redirect.

## Interface
- DEPTH, 4: FIFO entries; also the maximum number of outstanding memory requests (power of two, ≥2).
- XLEN, 32: address and instruction width.

- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low; one clock, and reset is synchronous active-low.
- pc_in  in  XLEN  current PC register output.
- pc_write_enable  out  1  PC register load enable.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (= pc_in).
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  instruction returned; in order; no backpressure.
- imem_resp_data  in  XLEN  returned instruction word.
- flush  in  1  branch/jump redirect; discards all buffered and in-flight fetches.
- id_valid  out  1  a buffered instruction is available to decode.
- id_instr  out  XLEN  head instruction; 32'h00000013 (NOP) when id_valid=0.
- id_pc  out  XLEN  PC of the head instruction; 0 when id_valid=0.
- id_ready  in  1  decode consumes the head this cycle.

## Operation
- States: IDLE (one cycle after reset), RUN, DRAIN.
  - IDLE→RUN unconditionally.
  - RUN→DRAIN on flush when in-flight responses remain after this cycle.
  - DRAIN→RUN when the drop counter reaches 0.
  - A flush in DRAIN adds nothing; no requests are outstanding.
- Counters:
  - `occ`: FIFO occupancy, 0..DEPTH.
  - `outst`: accepted requests without a response, 0..DEPTH.
  - `drop`: responses still to discard, 0..DEPTH.
  - All counters are registered.
- Credit: `occ + outst < DEPTH`, evaluated on registered values. A pop or response in the same cycle frees credit only from the next cycle.
- imem_req_valid = state==RUN && credit && !flush. imem_req_addr = pc_in.
- pc_write_enable = (imem_req_valid && imem_req_ready) || flush.
  - On flush, the external PC mux selects the redirect target and the PC loads it.
  - No request is issued in the flush cycle.
- Pending-PC queue (DEPTH entries):
  - On request acceptance, push pc_in.
  - On a non-dropped response, pop the PC and push {instr, pc} into the FIFO.
- Dropped response (`drop > 0`): decrement `drop` and `outst`; the FIFO is untouched.
- Flush: clear the FIFO and the pending-PC queue. Set `drop = outst - imem_resp_valid` and `outst` accordingly. A response arriving in the flush cycle is discarded.
- Pop when id_valid && id_ready && !flush.

## Timing
- Reset values:
  - state = IDLE; `occ` = `outst` = `drop` = 0.
  - imem_req_valid = 0, pc_write_enable = 0, id_valid = 0, id_instr = NOP, id_pc = 0.
- Request handshake: while valid && !ready, pc_write_enable = 0, so the PC and imem_req_addr hold stable.
- Latency: request accepted at edge N; earliest response in the cycle after N; instruction visible (id_valid=1) from the edge after the response. There is no response→decode bypass.
- FIFO full with id_ready=0: no credit, imem_req_valid=0, PC held.
- Push and pop in the same cycle are allowed at any occupancy; `occ` is unchanged.
- Flush together with id_ready: flush wins; the head is not consumed by decode and is cleared.
- Flush together with an accepted-eligible request: no request is issued.
- Reset in mid-operation: everything returns to reset values at the next edge. Stale memory responses are not tracked; memory is reset alongside.

## Structure
- Package `fetch_pkg`:
  - XLEN default.
  - NOP_INSTR = 32'h00000013.
  - typedef `fetch_entry_t` {instr, pc}.
  - enum `fetch_state_t` {IDLE, RUN, DRAIN}.
- Sub-module `fetch_fifo`:
  - Synchronous circular buffer parameterised by DEPTH and entry type.
  - Ports: push, pop, clear, full, empty, count, head.
  - Instantiated twice: once for the pending-PC queue, once for the instruction FIFO.
- Top level holds the FSM, credit logic and counters.

## Test plan
- Reset then a zero-wait memory with responses 1 cycle later, pc_in incrementing by 4 from 0x0 → id_valid rises 2 cycles after the first accept. The stream is {0x0,I0},{0x4,I1}… in order, one per cycle with id_ready=1.
- id_ready=0 held → exactly 4 requests accepted, then imem_req_valid=0 and pc_write_enable=0. Raising id_ready drains 0x0..0xC in order, after which fetch resumes.
- imem_req_ready low for 3 cycles with pc_in=0x40 → imem_req_addr stays 0x40 and pc_write_enable stays 0 throughout; accepted on the 4th cycle.
- Flush with 2 in-flight requests and 1 buffered entry:
  - Flush cycle: pc_write_enable=1, id_valid=0 the next cycle.
  - State is DRAIN and the 2 responses are discarded.
  - The first fetch after DRAIN uses the new pc_in = 0x100.
- Flush coinciding with imem_resp_valid and id_ready → that response is dropped, `drop` = `outst`−1, and the head is not delivered.
- reset asserted mid-stream with 3 buffered entries → next cycle id_valid=0, id_instr=0x00000013 and state IDLE; RUN one cycle after reset deasserts.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic [DEFAULT_XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] instr;
    logic [DEFAULT_XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular buffer with a combinational head view and a clear that
// overrides push and pop. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output entry_t                       head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full buffer is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC-tagged requests under a credit limit, pairs in-order
// responses with their PCs, and discards in-flight fetches after a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int XLEN  = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_write_enable,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            flush,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   occ, pend_count;
  logic            credit, req_accept, resp_fire, resp_drop, resp_keep, id_pop;
  logic            pend_full, pend_empty, instr_full, instr_empty;
  logic [XLEN-1:0] pend_head;
  fetch_entry_t    instr_push_data, instr_head;

  // Credit uses registered counts only, so frees take effect one cycle later.
  assign credit     = ({1'b0, occ} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign req_accept = imem_req_valid && imem_req_ready;
  assign resp_fire  = imem_resp_valid && (outst_q != '0);
  assign resp_drop  = resp_fire && (drop_q != '0);
  assign resp_keep  = resp_fire && (drop_q == '0) && !flush;
  assign id_pop     = id_valid && id_ready && !flush;

  always_comb begin
    outst_d = outst_q;
    drop_d  = drop_q;
    if (flush) begin
      // Everything still in flight after this cycle must be discarded on arrival.
      outst_d = outst_q - CW'(resp_fire);
      drop_d  = outst_d;
    end else begin
      outst_d = outst_q + CW'(req_accept) - CW'(resp_fire);
      drop_d  = drop_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (flush && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid  = (state_q == RUN) && credit && !flush;
    imem_req_addr   = pc_in;
    pc_write_enable = (imem_req_valid && imem_req_ready) || flush;
    id_valid        = !instr_empty;
    id_instr        = id_valid ? instr_head.instr : XLEN'(NOP_INSTR);
    id_pc           = id_valid ? instr_head.pc : '0;
  end

  assign instr_push_data = '{instr: imem_resp_data, pc: pend_head};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (logic [XLEN-1:0])
  ) u_pend_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_accept),
    .push_data (pc_in),
    .pop       (resp_keep),
    .clear     (flush),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (pend_count),
    .head      (pend_head)
  );

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_keep),
    .push_data (instr_push_data),
    .pop       (id_pop),
    .clear     (flush),
    .full      (instr_full),
    .empty     (instr_empty),
    .count     (occ),
    .head      (instr_head)
  );

  // Every in-flight fetch is either awaiting its PC pairing or marked for discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (pend_count == CW'(outst_q - drop_q));
      assert (!(resp_keep && pend_empty));
      assert (!(resp_keep && instr_full && !id_pop));
      assert (!(req_accept && pend_full));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc_in;
  logic            pc_write_enable;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_write_enable (pc_write_enable),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_ready        (id_ready)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model: decode buffer, PCs awaiting a response, discard count, external PC.
  ent_t         m_fifo[$];
  logic [31:0]  m_pend[$];
  int           m_drop;
  fetch_state_t m_st;
  logic [31:0]  m_pc;
  logic [31:0]  mem_addr[$];
  int           mem_due[$];
  int           cyc;

  int checks = 0;
  int errors = 0;

  logic         chk_en = 1'b0;
  logic         e_rv, e_we, e_idv;
  logic [31:0]  e_addr, e_instr, e_pc;
  fetch_state_t e_st;
  int           e_drop, e_outst;
  int           acc_cnt;
  logic [31:0]  last_acc_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req_valid", 32'(imem_req_valid), 32'(e_rv));
      check("imem_req_addr", imem_req_addr, e_addr);
      check("pc_write_enable", 32'(pc_write_enable), 32'(e_we));
      check("id_valid", 32'(id_valid), 32'(e_idv));
      check("id_instr", id_instr, e_instr);
      check("id_pc", id_pc, e_pc);
      check("state", 32'(dut.state_q), 32'(e_st));
      check("drop", 32'(dut.drop_q), 32'(e_drop));
      check("outst", 32'(dut.outst_q), 32'(e_outst));
      if (imem_req_valid && imem_req_ready) begin
        acc_cnt++;
        last_acc_addr = imem_req_addr;
      end
    end
  end

  task automatic cycle(input logic rst_n, input logic fl, input logic rr, input logic ir,
                       input int lat_lo, input int lat_hi, input logic [31:0] tgt);
    logic        resp;
    logic [31:0] rdata;
    ent_t        e;
    resp  = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    rdata = resp ? instr_of(mem_addr[0]) : $urandom;
    reset = rst_n;
    flush = fl;
    imem_req_ready  = rr;
    id_ready        = ir;
    pc_in           = m_pc;
    imem_resp_valid = resp;
    imem_resp_data  = rdata;

    e_rv    = (m_st == RUN) && (m_fifo.size() + m_pend.size() + m_drop < DEPTH) && !fl;
    e_we    = (e_rv && rr) || fl;
    e_addr  = m_pc;
    e_idv   = m_fifo.size() > 0;
    e_instr = e_idv ? m_fifo[0].instr : 32'h00000013;
    e_pc    = e_idv ? m_fifo[0].pc : 32'h0;
    e_st    = m_st;
    e_drop  = m_drop;
    e_outst = m_pend.size() + m_drop;

    @(negedge clk);
    if (!rst_n) begin
      m_fifo.delete();
      m_pend.delete();
      mem_addr.delete();
      mem_due.delete();
      m_drop = 0;
      m_st   = IDLE;
      m_pc   = 32'h0;
    end else begin
      if (resp) begin
        void'(mem_addr.pop_front());
        void'(mem_due.pop_front());
      end
      if (e_rv && rr) begin
        mem_addr.push_back(m_pc);
        mem_due.push_back(cyc + 1 + int'($urandom_range(lat_hi, lat_lo)));
      end
      if (fl) begin
        if (resp) begin
          if (m_drop > 0) m_drop--;
          else void'(m_pend.pop_front());
        end
        m_drop += m_pend.size();
        m_pend.delete();
        m_fifo.delete();
      end else begin
        if (e_idv && ir) void'(m_fifo.pop_front());
        if (resp) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.instr = rdata;
            e.pc    = m_pend.pop_front();
            m_fifo.push_back(e);
          end
        end
        if (e_rv && rr) m_pend.push_back(m_pc);
      end
      case (m_st)
        IDLE:    m_st = RUN;
        RUN:     if (fl && m_drop > 0) m_st = DRAIN;
        DRAIN:   if (m_drop == 0) m_st = RUN;
        default: m_st = IDLE;
      endcase
      if (e_we) m_pc = fl ? tgt : m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; pc_in = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
    m_drop = 0; m_st = IDLE; m_pc = 32'h0; cyc = 0; acc_cnt = 0; last_acc_addr = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset values and first-fetch latency with a zero-wait memory.
    do_reset();
    do_reset();
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_instr", id_instr, 32'h00000013);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("idle_to_run", 32'(dut.state_q), 32'(RUN));
    acc_cnt = 0;
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("first_accept", acc_cnt, 1);
    check("no_bypass", 32'(id_valid), 32'h0);
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("first_valid", 32'(id_valid), 32'h1);
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instr, 32'hCAFE0000);
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("second_pc", id_pc, 32'h4);
    check("second_instr", id_instr, 32'hCAFE0004);
    repeat (6) cycle(1, 0, 1, 1, 0, 0, 0);

    // Decode stalled: credit limits fetches to DEPTH, then drain in order.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 0);
    acc_cnt = 0;
    repeat (8) cycle(1, 0, 1, 0, 0, 0, 0);
    check("stall_accepts", acc_cnt, 4);
    check("stall_req_valid", 32'(imem_req_valid), 32'h0);
    check("stall_pcwe", 32'(pc_write_enable), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", id_pc, 32'(i * 4));
      cycle(1, 0, 1, 1, 0, 0, 0);
    end
    repeat (4) cycle(1, 0, 1, 1, 0, 1, 0);

    // Memory not ready: address and PC hold until accepted.
    do_reset();
    m_pc = 32'h40;
    cycle(1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 1, 0, 0, 0);
      check("hold_addr", imem_req_addr, 32'h40);
      check("hold_pcwe", 32'(pc_write_enable), 32'h0);
    end
    acc_cnt = 0;
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("hold_accept", acc_cnt, 1);
    check("hold_accept_addr", last_acc_addr, 32'h40);

    // Flush with two in flight and one buffered.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 5, 5, 0);
    cycle(1, 0, 1, 0, 5, 5, 0);
    check("pre_flush_valid", 32'(id_valid), 32'h1);
    cycle(1, 1, 1, 0, 0, 0, 32'h100);
    check("flush_pcwe", 32'(pc_write_enable), 32'h1);
    check("flush_no_req", 32'(imem_req_valid), 32'h0);
    check("flush_id_valid", 32'(id_valid), 32'h0);
    check("flush_state", 32'(dut.state_q), 32'(DRAIN));
    check("flush_drop", 32'(dut.drop_q), 32'h2);
    for (int k = 0; k < 12 && m_st != RUN; k++) cycle(1, 0, 1, 0, 0, 0, 0);
    check("drain_done", 32'(dut.state_q), 32'(RUN));
    acc_cnt = 0;
    cycle(1, 0, 1, 0, 0, 0, 0);
    check("redirect_accept", acc_cnt, 1);
    check("redirect_addr", last_acc_addr, 32'h100);

    // Flush together with a response and id_ready.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 1, 1, 0);
    cycle(1, 1, 1, 1, 0, 0, 32'h200);
    check("flush_resp_drop", 32'(dut.drop_q), 32'h1);
    check("flush_resp_outst", 32'(dut.outst_q), 32'h1);
    check("flush_resp_idv", 32'(id_valid), 32'h0);
    repeat (4) cycle(1, 0, 1, 1, 0, 0, 0);

    // Reset in the middle of a stream with three buffered entries.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 0);
    repeat (4) cycle(1, 0, 1, 0, 0, 0, 0);
    check("mid_valid", 32'(id_valid), 32'h1);
    do_reset();
    check("mid_rst_valid", 32'(id_valid), 32'h0);
    check("mid_rst_instr", id_instr, 32'h00000013);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("mid_rst_run", 32'(dut.state_q), 32'(RUN));

    // Randomised traffic with varying decode pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 500; n++) begin
        logic r_rst, r_fl, r_rr, r_ir;
        int   lat;
        r_rst = ($urandom_range(0, 199) != 0);
        r_fl  = ($urandom_range(0, 24) == 0);
        r_rr  = ($urandom_range(0, 9) < 7);
        r_ir  = ($urandom_range(0, 9) < 2 + ph);
        lat   = int'($urandom_range(0, 3));
        cycle(r_rst, r_fl, r_rr, r_ir, 0, lat, 32'($urandom_range(0, 32'h3FFF)) << 2);
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
